// File: rtl/adc_to_opfb_hls_deadlock_report_ctrl.sv
// adc_to_opfb_hls_deadlock_report_ctrl: confirms a deadlock request, launches a token trace from
// one origin process, then reports the visited set or aborts on timeout.
module adc_to_opfb_hls_deadlock_report_ctrl #(
   parameter int PROC_NUM       = 4,
   parameter int CONFIRM_CYCLES = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_return_vec,
   input  logic                report_ack,
   output logic                dl_detect_in,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic                token_clear,
   output logic                report_valid,
   output logic [PROC_NUM-1:0] report_origin,
   output logic [PROC_NUM-1:0] report_procs,
   output logic                timeout_err
);
   typedef enum logic [2:0] {IDLE, CONFIRM, ORIGIN, TRACE, CLEAR, REPORT, ABORT} state_t;
   localparam logic [7:0]  CONF_LAST = 8'(CONFIRM_CYCLES - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] TO_MAX    = 16'(TIMEOUT_CYCLES);
   state_t              state_q, state_d;
   logic [7:0]          conf_q, conf_d;
   logic [15:0]         trace_q, trace_d;
   logic [PROC_NUM-1:0] origin_q, origin_d, acc_q, acc_d, rorig_q, rorig_d, rprocs_q, rprocs_d;
   logic                terr_q, terr_d;
   logic [PROC_NUM-1:0] lowest;
   // two's-complement trick isolates the lowest set request bit
   assign lowest = dl_detect_vec & (-dl_detect_vec);
   always_comb begin
      state_d  = state_q;
      conf_d   = conf_q;
      trace_d  = trace_q;
      origin_d = origin_q;
      acc_d    = acc_q;
      rorig_d  = rorig_q;
      rprocs_d = rprocs_q;
      terr_d   = terr_q;
      case (state_q)
         IDLE: if (|dl_detect_vec) begin
            state_d = (CONFIRM_CYCLES == 1) ? ORIGIN : CONFIRM;
            conf_d  = (CONFIRM_CYCLES == 1) ? 8'd0 : 8'd1;
         end
         CONFIRM: if (!(|dl_detect_vec)) begin
            state_d = IDLE;
            conf_d  = 8'd0;
         end else if (conf_q == CONF_LAST) begin
            state_d = ORIGIN;
            conf_d  = 8'd0;
         end else conf_d = conf_q + 8'd1;
         ORIGIN: begin
            state_d = TRACE;
            trace_d = 16'd0;
            acc_d   = '0;
         end
         TRACE: begin
            acc_d   = acc_q | token_return_vec;
            trace_d = (trace_q == TO_MAX) ? trace_q : trace_q + 16'd1;
            if (|(token_return_vec & origin_q)) state_d = CLEAR;
            else if (trace_q == TO_LAST) state_d = ABORT;
         end
         CLEAR: begin
            state_d  = REPORT;
            rorig_d  = origin_q;
            rprocs_d = acc_q | origin_q;
         end
         REPORT: state_d = report_ack ? IDLE : REPORT;
         ABORT: begin
            state_d = IDLE;
            terr_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == ORIGIN) origin_d = lowest;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         conf_q   <= '0;
         trace_q  <= '0;
         origin_q <= '0;
         acc_q    <= '0;
         rorig_q  <= '0;
         rprocs_q <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         conf_q   <= conf_d;
         trace_q  <= trace_d;
         origin_q <= origin_d;
         acc_q    <= acc_d;
         rorig_q  <= rorig_d;
         rprocs_q <= rprocs_d;
         terr_q   <= terr_d;
      end
   end
   assign dl_detect_in  = (state_q != IDLE) && (state_q != CONFIRM);
   assign origin_vec    = (state_q == ORIGIN) ? origin_q : '0;
   assign token_clear   = (state_q == CLEAR) || (state_q == ABORT);
   assign report_valid  = (state_q == REPORT);
   assign report_origin = rorig_q;
   assign report_procs  = rprocs_q;
   assign timeout_err   = terr_q;
endmodule

// File: tb/tb_adc_to_opfb_hls_deadlock_report_ctrl.sv
// tb_adc_to_opfb_hls_deadlock_report_ctrl: scoreboard bench for the deadlock report controller.
module tb_adc_to_opfb_hls_deadlock_report_ctrl;
   typedef struct packed {logic [3:0] o; logic [3:0] p;} rpt_t;
   logic       clock = 1'b0, reset = 1'b1, report_ack = 1'b0;
   logic [3:0] dl_detect_vec = '0, token_return_vec = '0;
   logic       dl_detect_in, token_clear, report_valid, timeout_err;
   logic [3:0] origin_vec, report_origin, report_procs;
   int         checks = 0, errors = 0, tc_cnt = 0, tc0;
   logic       rv_prev = 1'b0;
   rpt_t       q[$];
   rpt_t       e;
   always #5 clock = ~clock;
   adc_to_opfb_hls_deadlock_report_ctrl #(.PROC_NUM(4), .CONFIRM_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec), .token_return_vec(token_return_vec),
      .report_ack(report_ack), .dl_detect_in(dl_detect_in), .origin_vec(origin_vec),
      .token_clear(token_clear), .report_valid(report_valid), .report_origin(report_origin),
      .report_procs(report_procs), .timeout_err(timeout_err));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic detect(input logic [3:0] v, input logic [3:0] exp_origin);
      dl_detect_vec = v;
      for (int i = 0; i < 3; i++) begin
         step();
         check("confirm_quiet", {dl_detect_in, origin_vec}, 0);
      end
      step();
      check("origin_pulse", origin_vec, exp_origin);
      check("origin_dl_in", dl_detect_in, 1);
      dl_detect_vec = '0;
   endtask
   // report fields are compared against the scoreboard on each report_valid rise
   always @(negedge clock) begin
      if (token_clear) tc_cnt <= tc_cnt + 1;
      if (report_valid && !rv_prev) begin
         if (q.size() == 0) check("rpt_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            check("rpt_origin", report_origin, e.o);
            check("rpt_procs", report_procs, e.p);
         end
      end
      rv_prev <= report_valid;
   end
   initial begin
      dl_detect_vec = 4'hF; token_return_vec = 4'hF; report_ack = 1'b1;
      step(); step();
      check("reset_outs", {dl_detect_in, origin_vec, token_clear, report_valid, report_origin, report_procs, timeout_err}, 0);
      reset = 1'b0; dl_detect_vec = '0; token_return_vec = '0; report_ack = 1'b0;
      dl_detect_vec = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step();
         check("short_quiet", {dl_detect_in, origin_vec}, 0);
      end
      dl_detect_vec = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("short_idle", {dl_detect_in, origin_vec, token_clear}, 0);
      end
      detect(4'b0110, 4'b0010);
      q.push_back('{o: 4'b0010, p: 4'b1110});
      step();
      check("trace_origin_off", origin_vec, 0);
      check("trace_dl_in", dl_detect_in, 1);
      token_return_vec = 4'b0100; step();
      token_return_vec = 4'b1000; step();
      token_return_vec = 4'b0010; step();
      token_return_vec = 4'b0000;
      check("clear_tc", token_clear, 1);
      step();
      check("report_tc_off", token_clear, 0);
      dl_detect_vec = 4'hF;
      for (int i = 0; i < 3; i++) begin
         check("report_hold", {report_valid, dl_detect_in}, 2'b11);
         step();
      end
      report_ack = 1'b1; step();
      report_ack = 1'b0; dl_detect_vec = '0;
      check("ack_idle", {report_valid, dl_detect_in}, 0);
      check("fields_kept", report_procs, 4'b1110);
      check("tc_count_report", tc_cnt, 1);
      detect(4'b1000, 4'b1000);
      token_return_vec = 4'b0111;
      repeat (16) step();
      check("to_still_trace", {token_clear, dl_detect_in}, 2'b01);
      step();
      check("abort_tc", token_clear, 1);
      check("abort_rv", report_valid, 0);
      step();
      token_return_vec = '0;
      check("timeout_err", timeout_err, 1);
      check("abort_keeps_rpt", {report_origin, report_procs}, 8'b0010_1110);
      check("tc_count_abort", tc_cnt, 2);
      repeat (3) step();
      check("timeout_sticky", {timeout_err, report_valid, token_clear}, 3'b100);
      reset = 1'b1; step(); reset = 1'b0;
      check("reset_clears", {timeout_err, report_origin, report_procs}, 0);
      detect(4'b0001, 4'b0001);
      q.push_back('{o: 4'b0001, p: 4'b0101});
      step();
      token_return_vec = 4'b0100; step();
      token_return_vec = 4'b0000;
      repeat (14) step();
      token_return_vec = 4'b0001; step();
      token_return_vec = 4'b0000;
      check("edge_clear_tc", token_clear, 1);
      step();
      check("edge_report", report_valid, 1);
      check("edge_no_terr", timeout_err, 0);
      tc0 = tc_cnt;
      report_ack = 1'b1; reset = 1'b1; step();
      check("reset_in_report", {dl_detect_in, origin_vec, token_clear, report_valid, report_origin, report_procs, timeout_err}, 0);
      report_ack = 1'b0; reset = 1'b0; step();
      check("reset_no_tc", tc_cnt, tc0);
      detect(4'b0100, 4'b0100);
      step();
      check("restart_trace", dl_detect_in, 1);
      reset = 1'b1; step();
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adc_to_opfb_hls_deadlock_report_ctrl.md
ADC_TO_OPFB_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: adc_to_opfb_hls_deadlock_report_ctrl

Interface
REQ-001 Parameter PROC_NUM, default 4, number of monitored processes, one deadlock detect unit per process.
REQ-002 Parameter CONFIRM_CYCLES, default 4, consecutive cycles a detect request must persist before tracing starts; legal range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum TRACE cycles before abort; legal range 2..65535.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dl_detect_vec  input  PROC_NUM  bit i = dl_detect_out of unit i.
REQ-007 token_return_vec  input  PROC_NUM  bit i = OR of token_out_vec of unit i (token presence at process i).
REQ-008 report_ack  input  1  consumer acknowledge of a held report.
REQ-009 dl_detect_in  output  1  broadcast to all units; freezes dependence propagation during trace.
REQ-010 origin_vec  output  PROC_NUM  one-hot origin strobe to the chosen unit.
REQ-011 token_clear  output  1  broadcast token clear strobe.
REQ-012 report_valid  output  1  deadlock report held.
REQ-013 report_origin  output  PROC_NUM  one-hot origin of the held report.
REQ-014 report_procs  output  PROC_NUM  set of processes the token visited.
REQ-015 timeout_err  output  1  sticky: a trace was aborted.

Function
REQ-016 FSM states IDLE, CONFIRM, ORIGIN, TRACE, CLEAR, REPORT, ABORT; encoding is free.
REQ-017 IDLE: dl_detect_vec != 0 -> CONFIRM with confirm counter = 1 (or ORIGIN directly if CONFIRM_CYCLES == 1); else stay.
REQ-018 CONFIRM: dl_detect_vec == 0 -> IDLE, counter cleared; nonzero and counter == CONFIRM_CYCLES-1 -> ORIGIN; else counter +1.
REQ-019 On entry to ORIGIN the lowest-index set bit of dl_detect_vec in the transition cycle is latched as one-hot origin register.
REQ-020 ORIGIN lasts exactly one cycle: origin_vec = origin register, dl_detect_in = 1; next state TRACE, trace counter = 0, report_procs accumulator cleared.
REQ-021 origin_vec is zero in every state except ORIGIN.
REQ-022 TRACE: dl_detect_in = 1; each cycle accumulator |= token_return_vec; trace counter +1 (saturating at TIMEOUT_CYCLES).
REQ-023 TRACE: token_return_vec & origin register != 0 -> CLEAR (return visible in first TRACE cycle is honoured); this takes priority over timeout in the same cycle.
REQ-024 TRACE: no return and trace counter == TIMEOUT_CYCLES-1 -> ABORT.
REQ-025 CLEAR: one cycle, token_clear = 1, dl_detect_in = 1; report_origin <= origin register, report_procs <= accumulator | origin register; next REPORT.
REQ-026 REPORT: report_valid = 1, dl_detect_in = 1, report fields stable; report_ack = 1 -> IDLE (report_valid low next cycle); dl_detect_vec ignored.
REQ-027 ABORT: one cycle, token_clear = 1, dl_detect_in = 1, timeout_err set to 1; next IDLE; report fields unchanged.
REQ-028 token_clear is high only in CLEAR and ABORT; dl_detect_in high in ORIGIN, TRACE, CLEAR, REPORT, ABORT, low in IDLE and CONFIRM.
REQ-029 report_ack outside REPORT has no effect; token_return_vec outside TRACE is ignored.
REQ-030 All outputs are registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-031 reset = 1 at a rising edge forces IDLE, clears all counters, origin register, accumulator, report_origin, report_procs, timeout_err; wins over every other event that cycle.
REQ-032 Output values during and after reset: dl_detect_in 0, origin_vec 0, token_clear 0, report_valid 0, report_origin 0, report_procs 0, timeout_err 0.
REQ-033 Reset asserted mid-trace or mid-report aborts without a token_clear pulse; the next detection restarts from IDLE.

Verification
REQ-034 PROC_NUM=4, CONFIRM_CYCLES=4: dl_detect_vec=4'b0110 held from cycle 0 -> origin_vec=4'b0010 for exactly one cycle at cycle 4, dl_detect_in high from cycle 4.
REQ-035 dl_detect_vec=4'b0001 for 3 cycles then 0 -> back to IDLE, no origin pulse, dl_detect_in stays 0.
REQ-036 Origin 4'b0010; token_return_vec 4'b0100, 4'b1000, 4'b0010 in TRACE cycles 1-3 -> token_clear one cycle, report_valid=1, report_procs=4'b1110, report_origin=4'b0010; held until report_ack, then IDLE.
REQ-037 TIMEOUT_CYCLES=16, no token return -> after 16 TRACE cycles one token_clear pulse, timeout_err=1 sticky, report_valid stays 0.
REQ-038 Token return on the same cycle the trace counter hits TIMEOUT_CYCLES-1 -> CLEAR/REPORT taken, timeout_err stays 0.
REQ-039 reset=1 during REPORT with report_ack=1 -> all outputs 0 next cycle, no token_clear pulse.
